// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the LEGv8 5-stage pipeline.
// Pipeline registers carry an if_id_t-style bundle of instruction, PC and valid flag.
package pipeline_pkg;

    localparam int PIPE_N = 64;
    localparam logic [31:0] NOP_INSTR = 32'hD503201F;

    typedef struct packed {
        logic [31:0]       instr;
        logic [PIPE_N-1:0] pc;
        logic              valid;
    } if_id_t;

endpackage

// File: rtl/adder.sv
// Generic N-bit modulo adder primitive.
module adder #(
    parameter int N = 64
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y
);

    assign y = a + b;

endmodule

// File: rtl/if_id_reg.sv
// Pipeline register holding an if_id_t bundle with enable and flush controls.
// Flush loads a bubble (NOP, valid=0) but keeps the stored pc; flush beats enable.
module if_id_reg
    import pipeline_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR_P = NOP_INSTR
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   en,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q.instr <= NOP_INSTR_P;
            q.pc    <= '0;
            q.valid <= 1'b0;
        end else if (flush) begin
            q.instr <= NOP_INSTR_P;
            q.valid <= 1'b0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mux2.sv
// Generic N-bit two-input multiplexer primitive (s=1 selects d1).
module mux2 #(
    parameter int N = 64
) (
    input  logic [N-1:0] d0,
    input  logic [N-1:0] d1,
    input  logic         s,
    output logic [N-1:0] y
);

    assign y = s ? d1 : d0;

endmodule

// File: rtl/fetch_stage.sv
// FETCH stage: PC register, next-PC selection, instruction-memory request and
// IF/ID register feeding DECODE. Handles redirect, stall and memory wait states.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter int          N         = PIPE_N,
    parameter logic [N-1:0] RESET_PC = '0,
    parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pcsrc_M,
    input  logic [N-1:0] pcbranch_M,
    input  logic         stall_F,
    output logic [N-1:0] imem_addr_F,
    input  logic [31:0]  imem_data_F,
    input  logic         imem_ready_F,
    output logic [31:0]  instr_D,
    output logic [N-1:0] pc_D,
    output logic         valid_D,
    output logic [31:0]  fetch_cnt
);

    logic [N-1:0] pc_q;
    logic [N-1:0] pc_plus4;
    logic [N-1:0] pc_seq;
    logic [N-1:0] pc_next;
    logic [N-1:0] branch_aligned;
    logic         hold_pc;
    logic         advance;
    logic         flush;
    if_id_t       if_id_d;
    if_id_t       if_id_q;

    // Redirect outranks stall and wait; only a clean cycle advances.
    assign hold_pc        = stall_F | ~imem_ready_F;
    assign advance        = ~pcsrc_M & ~stall_F & imem_ready_F;
    assign flush          = pcsrc_M | (~stall_F & ~imem_ready_F);
    assign branch_aligned = pcbranch_M & ~N'(3);

    adder #(.N(N)) u_pc_add (
        .a (pc_q),
        .b (N'(4)),
        .y (pc_plus4)
    );

    mux2 #(.N(N)) u_seq_mux (
        .d0 (pc_plus4),
        .d1 (pc_q),
        .s  (hold_pc),
        .y  (pc_seq)
    );

    mux2 #(.N(N)) u_branch_mux (
        .d0 (pc_seq),
        .d1 (branch_aligned),
        .s  (pcsrc_M),
        .y  (pc_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            fetch_cnt <= '0;
        end else begin
            pc_q <= pc_next;
            if (advance) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
        end
    end

    assign if_id_d.instr = imem_data_F;
    assign if_id_d.pc    = PIPE_N'(pc_q);
    assign if_id_d.valid = 1'b1;

    if_id_reg #(.NOP_INSTR_P(NOP_INSTR)) u_if_id (
        .clk   (clk),
        .reset (reset),
        .en    (~stall_F),
        .flush (flush),
        .d     (if_id_d),
        .q     (if_id_q)
    );

    assign imem_addr_F = pc_q;
    assign instr_D     = if_id_q.instr;
    assign pc_D        = N'(if_id_q.pc);
    assign valid_D     = if_id_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: reset, advance, stall,
// redirect, memory wait, reset during wait and PC wrap-around.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'hD503201F;

    logic        clk = 1'b0;
    logic        reset;
    logic        pcsrc_M;
    logic [63:0] pcbranch_M;
    logic        stall_F;
    logic [63:0] imem_addr_F;
    logic [31:0] imem_data_F;
    logic        imem_ready_F;
    logic [31:0] instr_D;
    logic [63:0] pc_D;
    logic        valid_D;
    logic [31:0] fetch_cnt;

    int errors = 0;
    int checks = 0;

    fetch_stage dut (
        .clk          (clk),
        .reset        (reset),
        .pcsrc_M      (pcsrc_M),
        .pcbranch_M   (pcbranch_M),
        .stall_F      (stall_F),
        .imem_addr_F  (imem_addr_F),
        .imem_data_F  (imem_data_F),
        .imem_ready_F (imem_ready_F),
        .instr_D      (instr_D),
        .pc_D         (pc_D),
        .valid_D      (valid_D),
        .fetch_cnt    (fetch_cnt)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: a distinct word derived from each address.
    function automatic logic [31:0] word_at(input logic [63:0] a);
        return 32'h8B00_0000 | {8'h00, a[23:0]};
    endfunction

    always_comb imem_data_F = word_at(imem_addr_F);

    task automatic applyStimulus(input logic rst, input logic br, input logic [63:0] tgt,
                                 input logic stl, input logic rdy);
        reset        = rst;
        pcsrc_M      = br;
        pcbranch_M   = tgt;
        stall_F      = stl;
        imem_ready_F = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkState(input string tag, input logic [63:0] addr, input logic [31:0] instr,
                              input logic [63:0] pcd, input logic vld, input logic [31:0] cnt);
        checkOutput({tag, ".imem_addr_F"}, imem_addr_F, addr);
        checkOutput({tag, ".instr_D"}, {32'h0, instr_D}, {32'h0, instr});
        checkOutput({tag, ".pc_D"}, pc_D, pcd);
        checkOutput({tag, ".valid_D"}, {63'h0, valid_D}, {63'h0, vld});
        checkOutput({tag, ".fetch_cnt"}, {32'h0, fetch_cnt}, {32'h0, cnt});
    endtask

    initial begin
        // Reset for two cycles
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b0, 1'b1);
        checkState("reset", 64'h0, NOP, 64'h0, 1'b0, 32'd0);

        // Advance twice to PC=8
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
        checkState("adv0", 64'h4, word_at(64'h0), 64'h0, 1'b1, 32'd1);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
        checkState("adv4", 64'h8, word_at(64'h4), 64'h4, 1'b1, 32'd2);

        // Stall two cycles at PC=8: everything frozen
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, 1'b1);
        checkState("stall1", 64'h8, word_at(64'h4), 64'h4, 1'b1, 32'd2);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, 1'b1);
        checkState("stall2", 64'h8, word_at(64'h4), 64'h4, 1'b1, 32'd2);

        // Release and finish the straight-line run
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
        checkState("adv8", 64'hC, word_at(64'h8), 64'h8, 1'b1, 32'd3);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
        checkState("adv12", 64'h10, word_at(64'hC), 64'hC, 1'b1, 32'd4);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
        checkState("adv16", 64'h14, word_at(64'h10), 64'h10, 1'b1, 32'd5);

        // Redirect to misaligned 0x103 together with a stall
        applyStimulus(1'b0, 1'b1, 64'h103, 1'b1, 1'b1);
        checkState("redir", 64'h100, NOP, 64'h10, 1'b0, 32'd5);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
        checkState("tgt100", 64'h104, word_at(64'h100), 64'h100, 1'b1, 32'd6);

        // Redirect to 0x20 while memory is not ready: word discarded
        applyStimulus(1'b0, 1'b1, 64'h20, 1'b0, 1'b0);
        checkState("redir20", 64'h20, NOP, 64'h100, 1'b0, 32'd6);

        // Three wait cycles at 0x20
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
            checkOutput("wait.imem_addr_F", imem_addr_F, 64'h20);
            checkOutput("wait.valid_D", {63'h0, valid_D}, 64'h0);
            checkOutput("wait.instr_D", {32'h0, instr_D}, {32'h0, NOP});
            checkOutput("wait.fetch_cnt", {32'h0, fetch_cnt}, 64'd6);
        end
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
        checkState("ready20", 64'h24, word_at(64'h20), 64'h20, 1'b1, 32'd7);

        // Enter wait again, then reset during the wait
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
        checkOutput("wait24.imem_addr_F", imem_addr_F, 64'h24);
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
        checkState("resetwait", 64'h0, NOP, 64'h0, 1'b0, 32'd0);

        // Branch to the top of the address space and wrap
        applyStimulus(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b1);
        checkState("redirtop", 64'hFFFF_FFFF_FFFF_FFFC, NOP, 64'h0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
        checkState("wraptop", 64'h0, word_at(64'hFFFF_FFFF_FFFF_FFFC),
                   64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 32'd1);
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
        checkState("wrap0", 64'h4, word_at(64'h0), 64'h0, 1'b1, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
